// File: rtl/machine_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : machine_host_ctrl
// Brief   : Host sequencer: streams an image into the machine core, runs it,
//           and streams the downscaled result back out.
// Revision: 1.0
// ============================================================================
module machine_host_ctrl #(
    parameter int IMG_W  = 256,
    parameter int OUT_W  = 128,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  m_status,
    output logic [15:0] m_addr,
    output logic [7:0]  m_data,
    input  logic        m_end_process,
    input  logic [7:0]  m_out
);

    localparam logic [15:0] c_LOAD_LAST = 16'(IMG_W * IMG_W - 1);
    localparam logic [15:0] c_READ_LAST = 16'(OUT_W * OUT_W - 1);
    localparam logic [7:0]  c_WAIT_INIT = 8'(RD_LAT - 1);

    localparam logic [1:0] c_MS_IDLE = 2'b00;
    localparam logic [1:0] c_MS_LOAD = 2'b10;
    localparam logic [1:0] c_MS_PROC = 2'b01;
    localparam logic [1:0] c_MS_READ = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_FLUSH   = 3'd2,
        S_PROC    = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_WAIT = 3'd5,
        S_RD_OUT  = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [7:0]  r_wait;

    logic w_in_hs;
    logic w_out_hs;

    assign w_in_hs  = in_valid & in_ready;
    assign w_out_hs = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wait    <= '0;
            in_ready  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            m_status  <= c_MS_IDLE;
            m_addr    <= '0;
            m_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_cnt    <= '0;
                        m_status <= c_MS_LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_in_hs) begin
                        m_addr <= r_cnt;
                        m_data <= in_data;
                        r_cnt  <= r_cnt + 16'd1;
                        if (r_cnt == c_LOAD_LAST) begin
                            in_ready <= 1'b0;
                            r_state  <= S_FLUSH;
                        end
                    end
                end
                // Status stays at load for one more edge so the core commits the last byte.
                S_FLUSH: begin
                    m_status <= c_MS_PROC;
                    r_state  <= S_PROC;
                end
                S_PROC: begin
                    if (m_end_process) begin
                        m_status <= c_MS_READ;
                        r_cnt    <= '0;
                        r_state  <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    m_addr  <= r_cnt;
                    r_wait  <= c_WAIT_INIT;
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (r_wait == 8'd0) begin
                        out_data  <= m_out;
                        out_valid <= 1'b1;
                        r_state   <= S_RD_OUT;
                    end else begin
                        r_wait <= r_wait - 8'd1;
                    end
                end
                S_RD_OUT: begin
                    if (w_out_hs) begin
                        out_valid <= 1'b0;
                        if (r_cnt == c_READ_LAST) begin
                            done    <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_cnt   <= r_cnt + 16'd1;
                            r_state <= S_RD_ADDR;
                        end
                    end
                end
                S_FIN: begin
                    done      <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    m_status  <= c_MS_IDLE;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_machine_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_machine_host_ctrl
// Brief   : Randomized bench with a behavioural machine-core model.
// Revision: 1.0
// ============================================================================
module tb_machine_host_ctrl;

    localparam int IMG_W  = 32;
    localparam int OUT_W  = 16;
    localparam int RD_LAT = 2;
    localparam int IMG_N  = IMG_W * IMG_W;
    localparam int OUT_N  = OUT_W * OUT_W;
    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [1:0]  m_status;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic        m_end_process = 1'b0;
    logic [7:0]  m_out = 8'd0;

    logic [7:0]  mem [IMG_N];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    machine_host_ctrl #(
        .IMG_W (IMG_W),
        .OUT_W (OUT_W),
        .RD_LAT(RD_LAT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .m_status     (m_status),
        .m_addr       (m_addr),
        .m_data       (m_data),
        .m_end_process(m_end_process),
        .m_out        (m_out)
    );

    // Core model: writes memory in load status, read data valid RD_LAT edges after the address.
    always @(posedge clk) begin
        if (m_status == 2'b10 && int'(m_addr) < IMG_N)
            mem[int'(m_addr)] <= m_data;
        m_out <= m_addr[7:0] ^ 8'h5A;
    end

    function automatic logic [7:0] pix(input int sel, input int i);
        int t;
        case (sel)
            0:       t = i;
            1:       t = i * 37 + 11;
            default: t = i * 91 + 200;
        endcase
        return t[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string where);
        check({where, "_status"},    32'(m_status),  32'd0);
        check({where, "_addr"},      32'(m_addr),    32'd0);
        check({where, "_data"},      32'(m_data),    32'd0);
        check({where, "_in_ready"},  32'(in_ready),  32'd0);
        check({where, "_out_valid"}, 32'(out_valid), 32'd0);
        check({where, "_out_data"},  32'(out_data),  32'd0);
        check({where, "_busy"},      32'(busy),      32'd0);
        check({where, "_done"},      32'(done),      32'd0);
    endtask

    task automatic run(input int sel, input int abort_load, input int abort_rd);
        int   idx;
        int   k;
        int   bad;
        int   guard;
        logic v;
        logic r;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_status",   32'(m_status), 32'd2);
        check("start_in_ready", 32'(in_ready), 32'd1);
        check("start_busy",     32'(busy),     32'd1);

        idx = 0;
        guard = 0;
        while (idx < IMG_N) begin
            if (idx == abort_load) begin
                in_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset("rst_load");
                return;
            end
            if (guard++ > BUDGET) begin
                check("load_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
            v = ($urandom_range(3) != 0);
            in_valid = v;
            in_data = pix(sel, idx);
            if (v && in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("flush_status",   32'(m_status), 32'd2);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("last_addr",      32'(m_addr),   32'(IMG_N - 1));
        check("last_data",      32'(m_data),   32'(pix(sel, IMG_N - 1)));
        @(negedge clk);
        check("proc_status", 32'(m_status), 32'd1);

        bad = 0;
        for (int i = 0; i < IMG_N; i++)
            if (mem[i] !== pix(sel, i)) bad++;
        check("mem_mismatches", 32'(bad), 32'd0);

        bad = 0;
        for (int c = 0; c < 500; c++) begin
            start = ($urandom_range(7) == 0);
            in_valid = 1'($urandom_range(1));
            in_data = 8'($urandom_range(255));
            @(negedge clk);
            if (m_status !== 2'b01 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        m_end_process = 1'b1;
        @(negedge clk);
        m_end_process = 1'b0;
        check("proc_bad_cycles", 32'(bad), 32'd0);
        check("rd_status", 32'(m_status), 32'd3);

        k = 0;
        guard = 0;
        bad = 0;
        while (k < OUT_N) begin
            if (k == abort_rd && out_valid) begin
                out_ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset("rst_rd");
                return;
            end
            if (guard++ > BUDGET) begin
                check("rd_timeout", 32'd0, 32'd1);
                out_ready = 1'b0;
                start = 1'b0;
                return;
            end
            if (done || in_ready || m_status !== 2'b11) bad++;
            r = ($urandom_range(2) != 0);
            out_ready = r;
            start = ($urandom_range(15) == 0);
            if (out_valid && r) begin
                check("rd_byte", 32'(out_data), 32'(8'(k) ^ 8'h5A));
                k++;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        start = 1'b0;
        check("rd_bad_cycles", 32'(bad), 32'd0);
        check("fin_done",      32'(done),      32'd1);
        check("fin_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("idle_done",   32'(done),     32'd0);
        check("idle_status", 32'(m_status), 32'd0);
        check("idle_busy",   32'(busy),     32'd0);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_busy", 32'(busy), 32'd0);

        run(0, -1, -1);
        run(1, -1, -1);
        run(0, 100, -1);
        @(negedge clk);
        run(1, -1, 50);
        @(negedge clk);
        run(2, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
